// File: rtl/wb_mem_responder.sv
`timescale 1ns/1ps
// Wishbone classic-cycle responder backed by a small byte-lane writable word memory.
// Each request ends in ack, err or rty after WAIT_STATES idle cycles; the top word is a doorbell driving inta.
module wb_mem_responder #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 16,
  parameter int                       MEM_DEPTH     = 64,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       WAIT_STATES   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cyc,
  input  logic                       stb,
  input  logic [WB_ADDR_WIDTH-1:0]   adr,
  input  logic                       we,
  input  logic [WB_DATA_WIDTH/8-1:0] sel,
  input  logic [WB_DATA_WIDTH-1:0]   dout,
  input  logic                       hold,
  output logic [WB_DATA_WIDTH-1:0]   din,
  output logic                       ack,
  output logic                       err,
  output logic                       rty,
  output logic                       inta
);

  localparam int                       SEL_W    = WB_DATA_WIDTH / 8;
  localparam int                       IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [WB_ADDR_WIDTH-1:0] DEPTH_A  = WB_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [WB_ADDR_WIDTH-1:0] BELL_OFF = WB_ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [3:0]               CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [3:0]                 cnt;
  logic [3:0]                 cnt_nxt;
  logic                       capture;

  logic [WB_ADDR_WIDTH-1:0]   cap_adr;
  logic                       cap_we;
  logic [SEL_W-1:0]           cap_sel;
  logic [WB_DATA_WIDTH-1:0]   cap_dat;

  logic [WB_DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic                       inta_q;

  logic [WB_ADDR_WIDTH-1:0]   offset;
  logic [IDX_W-1:0]           idx;
  logic                       in_range;
  logic                       is_bell;
  logic                       in_resp;

  // An address below the base wraps to a huge offset, so the lower bound is checked explicitly too.
  assign offset   = cap_adr - BASE_ADDR;
  assign in_range = (cap_adr >= BASE_ADDR) && (offset < DEPTH_A);
  assign idx      = offset[IDX_W-1:0];
  assign is_bell  = (offset == BELL_OFF);
  assign in_resp  = (state == RESP);

  // NOTE: every signal written here gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cyc && stb) begin
          capture   = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the capture registers carry no reset; they are only observed in RESP, which always follows a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      cap_adr <= adr;
      cap_we  <= we;
      cap_sel <= sel;
      cap_dat <= dout;
    end
  end

  // NOTE: the memory must read back zero after reset, so it is a register array cleared by a reset loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      inta_q <= 1'b0;
    end else if (ack) begin
      if (cap_we) begin
        for (int b = 0; b < SEL_W; b++) begin
          if (cap_sel[b]) begin
            mem[idx][8*b +: 8] <= cap_dat[8*b +: 8];
          end
        end
      end
      // Doorbell: a write with any lane set rings it, a read acknowledges it.
      if (is_bell) begin
        if (cap_we && (|cap_sel)) begin
          inta_q <= 1'b1;
        end else if (!cap_we) begin
          inta_q <= 1'b0;
        end
      end
    end
  end

  // Terminations decode registered state; hold only steers the RESP cycle.
  assign rty  = in_resp && hold;
  assign err  = in_resp && !hold && !in_range;
  assign ack  = in_resp && !hold && in_range;
  assign din  = (ack && !cap_we) ? mem[idx] : '0;
  assign inta = inta_q;

endmodule
